// File: rtl/sram_read_streamer.sv
// sram_read_streamer
//   Streams a run of consecutive 32-bit words out of an asynchronous,
//   read-only-used SRAM into a small output FIFO. One command supplies a
//   start word address and a word count. Addresses are registered onto
//   SRAM_ADDR, the returned word is sampled at the end of the cycle its
//   address is presented, and the word is pushed into the FIFO. Address
//   issue is throttled so the FIFO can never overflow, which lets the sink
//   stall arbitrarily.
//
// Handshakes: both the command port (cmd_valid/cmd_ready) and the read port
//   (rd_valid/rd_ready) transfer on a rising clk edge where valid and ready
//   are both high. A valid source holds its payload stable until the
//   transfer; ready may be driven freely.
//
// Ports
//   clk, rst             clock; synchronous active-low reset
//   cmd_valid/cmd_ready  command handshake (ready only while IDLE)
//   cmd_addr[17:0]       first word address
//   cmd_len[15:0]        number of words (0 = consume and ignore)
//   rd_valid/rd_ready    output word handshake
//   rd_data[31:0]        output word, rd_last marks the final word of a command
//   busy                 state is not IDLE
//   state_dbg[1:0]       current FSM state (IDLE=0, RUN=1, DRAIN=2)
//   SRAM_*               SRAM pins; data bus is never driven by this block
module sram_read_streamer #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [17:0] cmd_addr,
   input  logic [15:0] cmd_len,
   output logic        rd_valid,
   input  logic        rd_ready,
   output logic [31:0] rd_data,
   output logic        rd_last,
   output logic        busy,
   output logic [1:0]  state_dbg,
   inout  wire  [31:0] SRAM_DATA,
   output logic [17:0] SRAM_ADDR,
   output logic        SRAM_CE_N,
   output logic        SRAM_OE_N,
   output logic        SRAM_WE_N,
   output logic        SRAM_CE2_N,
   output logic        SRAM_SW_A_N,
   output logic        SRAM_SW_B_N,
   output logic        SRAM_SW_C_N,
   output logic        SRAM_SW_D_N
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t state, state_next;

   // Issue datapath
   logic [17:0] next_addr;      // address to issue next while in RUN
   logic [15:0] remain;         // addresses still to issue
   logic        inflight;       // an issued address is on SRAM_ADDR this cycle
   logic        inflight_last;  // that address is the final one of the command
   logic [17:0] sram_addr_q;
   logic        ce_n_q;
   logic        oe_n_q;

   // Output FIFO
   logic [32:0]   mem [DEPTH];  // {last, data}
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;

   logic          accept;
   logic          push;
   logic          pop;
   logic [CW:0]   occ;
   logic          room;
   logic          issue;
   logic [17:0]   issue_addr;
   logic          issue_last;
   logic [32:0]   head;

   // Pins this block never uses for writing.
   assign SRAM_DATA   = 32'hzzzz_zzzz;
   assign SRAM_WE_N   = 1'b1;
   assign SRAM_CE2_N  = 1'b0;
   assign SRAM_SW_A_N = 1'b0;
   assign SRAM_SW_B_N = 1'b0;
   assign SRAM_SW_C_N = 1'b0;
   assign SRAM_SW_D_N = 1'b0;

   assign SRAM_ADDR = sram_addr_q;
   assign SRAM_CE_N = ce_n_q;
   assign SRAM_OE_N = oe_n_q;

   assign cmd_ready = (state == IDLE);
   assign busy      = (state != IDLE);
   assign state_dbg = state;
   assign accept    = cmd_valid && cmd_ready;

   assign head     = mem[rd_ptr];
   assign rd_valid = (count != '0);
   assign rd_data  = head[31:0];
   assign rd_last  = rd_valid && head[32];

   assign push = inflight;
   assign pop  = rd_valid && rd_ready;

   // Credit check: a word that leaves the FIFO this cycle frees its slot in
   // time for the address issued now, so a pop counts against occupancy.
   // This is what lets DEPTH=2 stream one word per cycle.
   assign occ  = {1'b0, count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop};
   assign room = (occ < (CW+1)'(DEPTH));

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // The first address is issued on the accept edge itself so that
   // SRAM_ADDR carries cmd_addr in the very next cycle.
   always_comb begin
      state_next = state;
      issue      = 1'b0;
      issue_addr = next_addr;
      issue_last = 1'b0;
      case (state)
         IDLE: begin
            if (accept && (cmd_len != 16'd0)) begin
               issue      = 1'b1;
               issue_addr = cmd_addr;
               issue_last = (cmd_len == 16'd1);
               state_next = RUN;
            end
         end
         RUN: begin
            if (remain == 16'd0) begin
               state_next = DRAIN;
            end else if (room) begin
               issue      = 1'b1;
               issue_addr = next_addr;
               issue_last = (remain == 16'd1);
               if (remain == 16'd1) begin
                  state_next = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (!inflight && (count == '0)) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         sram_addr_q   <= 18'd0;
         next_addr     <= 18'd0;
         remain        <= 16'd0;
         inflight      <= 1'b0;
         inflight_last <= 1'b0;
         ce_n_q        <= 1'b1;
         oe_n_q        <= 1'b1;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         count         <= '0;
      end else begin
         // Chip stays selected for the whole command, released on return to IDLE.
         ce_n_q   <= (state_next == IDLE);
         oe_n_q   <= (state_next == IDLE);
         inflight <= issue;
         if (issue) begin
            sram_addr_q   <= issue_addr;
            next_addr     <= issue_addr + 18'd1;
            inflight_last <= issue_last;
            remain        <= (state == IDLE) ? (cmd_len - 16'd1) : (remain - 16'd1);
         end
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         count <= count + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
      end
   end

   // FIFO storage needs no reset; pointers and count define what is valid.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= {inflight_last, SRAM_DATA};
      end
   end

endmodule

// File: tb/tb_sram_read_streamer.sv
// Directed bench for sram_read_streamer. The SRAM model returns
// {14'h0, address} for whatever address is presented.
module tb_sram_read_streamer;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [17:0] cmd_addr = 18'd0;
   logic [15:0] cmd_len = 16'd0;
   logic        rd_valid;
   logic        rd_ready = 1'b0;
   logic [31:0] rd_data;
   logic        rd_last;
   logic        busy;
   logic [1:0]  state_dbg;
   wire  [31:0] sram_data;
   logic [17:0] sram_addr;
   logic        sram_ce_n, sram_oe_n, sram_we_n, sram_ce2_n;
   logic        sw_a_n, sw_b_n, sw_c_n, sw_d_n;

   int          n_checks = 0;
   int          n_pass = 0;
   logic [31:0] exp_q[$];

   // clock/reset block
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, checks %0d passed %0d", n_checks, n_pass);
      $fatal(1, "watchdog");
   end

   // SRAM model
   assign sram_data = {14'h0, sram_addr};

   sram_read_streamer #(.DEPTH(4)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
      .busy(busy), .state_dbg(state_dbg),
      .SRAM_DATA(sram_data), .SRAM_ADDR(sram_addr),
      .SRAM_CE_N(sram_ce_n), .SRAM_OE_N(sram_oe_n), .SRAM_WE_N(sram_we_n),
      .SRAM_CE2_N(sram_ce2_n),
      .SRAM_SW_A_N(sw_a_n), .SRAM_SW_B_N(sw_b_n), .SRAM_SW_C_N(sw_c_n), .SRAM_SW_D_N(sw_d_n)
   );

   // driver: advance to 1 time unit after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0; cmd_valid = 1'b1; cmd_addr = 18'h5; cmd_len = 16'd4; rd_ready = 1'b1;
      tick(); tick();
      n_checks++; if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); else n_pass++;
      n_checks++; if (rd_valid !== 1'b0) $display("FAIL reset_rd_valid: got %b want 0", rd_valid); else n_pass++;
      n_checks++; if (rd_last !== 1'b0) $display("FAIL reset_rd_last: got %b want 0", rd_last); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
      n_checks++; if ({sram_ce_n, sram_oe_n, sram_we_n} !== 3'b111) $display("FAIL reset_ce_oe_we: got %b want 111", {sram_ce_n, sram_oe_n, sram_we_n}); else n_pass++;
      n_checks++; if (sram_addr !== 18'h0) $display("FAIL reset_sram_addr: got %h want 00000", sram_addr); else n_pass++;
      n_checks++; if ({sram_ce2_n, sw_a_n, sw_b_n, sw_c_n, sw_d_n} !== 5'b0) $display("FAIL reset_tieoffs: got %b want 00000", {sram_ce2_n, sw_a_n, sw_b_n, sw_c_n, sw_d_n}); else n_pass++;
      cmd_valid = 1'b0;
      rst = 1'b1;
      tick();
      n_checks++; if (busy !== 1'b0 || sram_ce_n !== 1'b1) $display("FAIL reset_no_accept: busy %b ce_n %b want 0 1", busy, sram_ce_n); else n_pass++;
   endtask

   task automatic test_stream();
      int t;
      exp_q.delete();
      for (int i = 0; i < 4; i++) exp_q.push_back(32'h10 + i);
      cmd_valid = 1'b1; cmd_addr = 18'h00010; cmd_len = 16'd4; rd_ready = 1'b1;
      n_checks++; if (cmd_ready !== 1'b1) $display("FAIL stream_cmd_ready: got %b want 1", cmd_ready); else n_pass++;
      tick();
      cmd_valid = 1'b0;
      n_checks++; if (sram_addr !== 18'h00010) $display("FAIL stream_addr_c1: got %h want 00010", sram_addr); else n_pass++;
      n_checks++; if ({sram_ce_n, sram_oe_n} !== 2'b00) $display("FAIL stream_ce_oe_c1: got %b want 00", {sram_ce_n, sram_oe_n}); else n_pass++;
      n_checks++; if ({busy, cmd_ready, rd_valid} !== 3'b100) $display("FAIL stream_busy_ready_valid_c1: got %b want 100", {busy, cmd_ready, rd_valid}); else n_pass++;
      for (int c = 2; c <= 5; c++) begin
         tick();
         n_checks++;
         if ({rd_valid, rd_last, rd_data} !== {1'b1, (c == 5), exp_q[0]})
            $display("FAIL stream_word_c%0d: got v%b l%b %h want v1 l%b %h", c, rd_valid, rd_last, rd_data, (c == 5), exp_q[0]);
         else n_pass++;
         void'(exp_q.pop_front());
      end
      t = 0;
      while (busy && t < 20) begin tick(); t++; end
      n_checks++; if (busy !== 1'b0) $display("FAIL stream_busy_falls: got %b want 0", busy); else n_pass++;
      n_checks++; if ({rd_valid, sram_ce_n, sram_oe_n} !== 3'b011) $display("FAIL stream_idle_after: got %b want 011", {rd_valid, sram_ce_n, sram_oe_n}); else n_pass++;
   endtask

   task automatic test_single_word();
      int t;
      cmd_valid = 1'b1; cmd_addr = 18'h00055; cmd_len = 16'd1; rd_ready = 1'b1;
      tick();
      cmd_valid = 1'b0;
      n_checks++; if (sram_addr !== 18'h00055) $display("FAIL single_addr: got %h want 00055", sram_addr); else n_pass++;
      tick();
      n_checks++;
      if ({rd_valid, rd_last, rd_data} !== {2'b11, 32'h55}) $display("FAIL single_word: got v%b l%b %h want v1 l1 00000055", rd_valid, rd_last, rd_data);
      else n_pass++;
      tick();
      n_checks++; if (rd_valid !== 1'b0) $display("FAIL single_no_extra: got %b want 0", rd_valid); else n_pass++;
      t = 0;
      while (busy && t < 20) begin tick(); t++; end
      n_checks++; if (busy !== 1'b0) $display("FAIL single_busy_falls: got %b want 0", busy); else n_pass++;
   endtask

   task automatic test_backpressure();
      int          t;
      int          issues;
      int          got;
      logic [17:0] prev;
      exp_q.delete();
      for (int i = 0; i < 8; i++) exp_q.push_back(32'h100 + i);
      prev = sram_addr;
      issues = 0;
      cmd_valid = 1'b1; cmd_addr = 18'h00100; cmd_len = 16'd8; rd_ready = 1'b0;
      for (int c = 1; c <= 12; c++) begin
         tick();
         cmd_valid = 1'b0;
         if (sram_addr !== prev) issues++;
         prev = sram_addr;
      end
      n_checks++; if (issues != 4) $display("FAIL bp_issued_while_stalled: got %0d want 4", issues); else n_pass++;
      n_checks++; if (sram_addr !== 18'h00103) $display("FAIL bp_addr_held: got %h want 00103", sram_addr); else n_pass++;
      n_checks++;
      if ({rd_valid, rd_last, rd_data} !== {2'b10, 32'h100}) $display("FAIL bp_head_stable: got v%b l%b %h want v1 l0 00000100", rd_valid, rd_last, rd_data);
      else n_pass++;
      tick();
      rd_ready = 1'b1;
      got = 0;
      t = 0;
      while (exp_q.size() != 0 && t < 40) begin
         if (rd_valid && rd_ready) begin
            n_checks++;
            if ({rd_last, rd_data} !== {(exp_q.size() == 1), exp_q[0]})
               $display("FAIL bp_word%0d: got l%b %h want l%b %h", got, rd_last, rd_data, (exp_q.size() == 1), exp_q[0]);
            else n_pass++;
            void'(exp_q.pop_front());
            got++;
         end
         tick();
         t++;
      end
      n_checks++; if (got != 8) $display("FAIL bp_word_count: got %0d want 8", got); else n_pass++;
      t = 0;
      while (busy && t < 20) begin tick(); t++; end
      n_checks++; if ({busy, rd_valid} !== 2'b00) $display("FAIL bp_drained: got busy %b valid %b want 0 0", busy, rd_valid); else n_pass++;
   endtask

   task automatic test_wrap();
      int          t;
      int          got;
      logic [17:0] addr_seq [3];
      addr_seq[0] = 18'h3FFFE; addr_seq[1] = 18'h3FFFF; addr_seq[2] = 18'h00000;
      exp_q.delete();
      exp_q.push_back(32'h0003FFFE); exp_q.push_back(32'h0003FFFF); exp_q.push_back(32'h00000000);
      cmd_valid = 1'b1; cmd_addr = 18'h3FFFE; cmd_len = 16'd3; rd_ready = 1'b0;
      got = 0;
      for (int c = 1; c <= 30 && exp_q.size() != 0; c++) begin
         tick();
         cmd_valid = 1'b0;
         if (c <= 3) begin
            n_checks++;
            if (sram_addr !== addr_seq[c-1]) $display("FAIL wrap_addr_c%0d: got %h want %h", c, sram_addr, addr_seq[c-1]);
            else n_pass++;
         end
         rd_ready = (c % 2 == 1);
         if (rd_valid && rd_ready) begin
            n_checks++;
            if ({rd_last, rd_data} !== {(exp_q.size() == 1), exp_q[0]})
               $display("FAIL wrap_word%0d: got l%b %h want l%b %h", got, rd_last, rd_data, (exp_q.size() == 1), exp_q[0]);
            else n_pass++;
            void'(exp_q.pop_front());
            got++;
         end
      end
      n_checks++; if (got != 3) $display("FAIL wrap_word_count: got %0d want 3", got); else n_pass++;
      tick();
      rd_ready = 1'b1;
      t = 0;
      while (busy && t < 20) begin tick(); t++; end
      n_checks++; if ({busy, rd_valid} !== 2'b00) $display("FAIL wrap_drained: got busy %b valid %b want 0 0", busy, rd_valid); else n_pass++;
   endtask

   task automatic test_zero_len();
      int bad;
      cmd_valid = 1'b1; cmd_addr = 18'h00777; cmd_len = 16'd0; rd_ready = 1'b1;
      n_checks++; if (cmd_ready !== 1'b1) $display("FAIL zero_cmd_ready: got %b want 1", cmd_ready); else n_pass++;
      tick();
      cmd_valid = 1'b0;
      n_checks++; if ({busy, cmd_ready} !== 2'b01) $display("FAIL zero_back_idle: got busy %b ready %b want 0 1", busy, cmd_ready); else n_pass++;
      bad = 0;
      for (int c = 0; c < 5; c++) begin
         if (rd_valid !== 1'b0 || sram_ce_n !== 1'b1) bad++;
         tick();
      end
      n_checks++; if (bad != 0) $display("FAIL zero_no_output: got %0d bad cycles want 0", bad); else n_pass++;
   endtask

   task automatic test_mid_reset();
      int t;
      int got;
      int extra;
      cmd_valid = 1'b1; cmd_addr = 18'h00200; cmd_len = 16'd16; rd_ready = 1'b0;
      tick();
      cmd_valid = 1'b0;
      for (int c = 0; c < 5; c++) tick();
      n_checks++; if ({busy, rd_valid} !== 2'b11) $display("FAIL mrst_prefill: got busy %b valid %b want 1 1", busy, rd_valid); else n_pass++;
      rst = 1'b0;
      tick();
      rst = 1'b1;
      n_checks++; if (rd_valid !== 1'b0) $display("FAIL mrst_rd_valid: got %b want 0", rd_valid); else n_pass++;
      n_checks++;
      if ({busy, cmd_ready, sram_ce_n, sram_oe_n, sram_addr} !== {4'b0111, 18'h0})
         $display("FAIL mrst_outputs: got busy %b ready %b ce %b oe %b addr %h want 0 1 1 1 00000", busy, cmd_ready, sram_ce_n, sram_oe_n, sram_addr);
      else n_pass++;
      rd_ready = 1'b1;
      extra = 0;
      for (int c = 0; c < 3; c++) begin
         if (rd_valid !== 1'b0) extra++;
         tick();
      end
      n_checks++; if (extra != 0) $display("FAIL mrst_stale_words: got %0d want 0", extra); else n_pass++;
      exp_q.delete();
      exp_q.push_back(32'h300); exp_q.push_back(32'h301);
      cmd_valid = 1'b1; cmd_addr = 18'h00300; cmd_len = 16'd2;
      tick();
      cmd_valid = 1'b0;
      got = 0;
      extra = 0;
      t = 0;
      while (t < 20) begin
         if (rd_valid && rd_ready) begin
            if (exp_q.size() == 0) extra++;
            else begin
               n_checks++;
               if ({rd_last, rd_data} !== {(exp_q.size() == 1), exp_q[0]})
                  $display("FAIL mrst_word%0d: got l%b %h want l%b %h", got, rd_last, rd_data, (exp_q.size() == 1), exp_q[0]);
               else n_pass++;
               void'(exp_q.pop_front());
               got++;
            end
         end
         tick();
         t++;
      end
      n_checks++; if (got != 2 || extra != 0) $display("FAIL mrst_count: got %0d words %0d extra want 2 0", got, extra); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL mrst_busy_falls: got %b want 0", busy); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_stream();
      test_single_word();
      test_backpressure();
      test_wrap();
      test_zero_len();
      test_mid_reset();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
